// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: FSM states, opcodes,
// datapath mux selects and ALU operation codes.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECUTER,
        S_EXECUTEI,
        S_ALUWB,
        S_BEQ,
        S_JAL
    } state_t;

    localparam logic [6:0] OP_LW    = 7'd3;
    localparam logic [6:0] OP_ALUI  = 7'd19;
    localparam logic [6:0] OP_SW    = 7'd35;
    localparam logic [6:0] OP_RTYPE = 7'd51;
    localparam logic [6:0] OP_BEQ   = 7'd99;
    localparam logic [6:0] OP_JAL   = 7'd111;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_MEMDATA   = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    function automatic logic is_supported(input logic [6:0] op);
        return (op == OP_LW) || (op == OP_ALUI) || (op == OP_SW) ||
               (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_JAL);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control/datapath boundary of the multi-cycle core: instruction fields and
// flags into the controller, mux selects and strobes back to the datapath.
interface multicycle_ctrl_if;
    logic [6:0] instrucOp;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       memReady;
    logic       pcWrite;
    logic       irWrite;
    logic       adrSrc;
    logic       memWrite;
    logic       memReq;
    logic       regWrite;
    logic [1:0] resultSrc;
    logic [1:0] aluSrcA;
    logic [1:0] aluSrcB;
    logic [2:0] aluControl;
    logic       illegalOp;

    modport master (
        input  instrucOp, funct3, funct7b5, zero, memReady,
        output pcWrite, irWrite, adrSrc, memWrite, memReq, regWrite,
               resultSrc, aluSrcA, aluSrcB, aluControl, illegalOp
    );

    modport slave (
        output instrucOp, funct3, funct7b5, zero, memReady,
        input  pcWrite, irWrite, adrSrc, memWrite, memReq, regWrite,
               resultSrc, aluSrcA, aluSrcB, aluControl, illegalOp
    );
endinterface

// File: rtl/alu_decoder.sv
// Maps the controller's coarse aluOp plus instruction function bits onto the
// concrete ALU operation code.
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       op_b5,
    input  logic       funct7b5,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // Only R-type (op bit 5 set) can select sub; addi ignores funct7.
                    3'b000:  alu_control = (op_b5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main instruction-sequencing FSM of the multi-cycle RV32I core.
// Define MEM_WAIT_EN to stall FETCH/MEMREAD/MEMWRITE until memReady.
module multicycle_ctrl
    import riscv_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    multicycle_ctrl_if.master bus
);

    state_t     state, state_next;
    logic       mem_ready;
    logic       pc_update, branch;
    logic       ir_write_raw, mem_req_raw, mem_write_raw, reg_write_raw, adr_src_raw;
    logic       illegal_raw;
    logic [1:0] alu_op, result_src, src_a, src_b;

`ifdef MEM_WAIT_EN
    assign mem_ready = bus.memReady;
`else
    logic mem_ready_unused;
    assign mem_ready_unused = bus.memReady;
    assign mem_ready        = 1'b1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_FETCH;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_FETCH:    if (mem_ready) state_next = S_DECODE;
            S_DECODE: begin
                case (bus.instrucOp)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYPE:     state_next = S_EXECUTER;
                    OP_ALUI:      state_next = S_EXECUTEI;
                    OP_BEQ:       state_next = S_BEQ;
                    OP_JAL:       state_next = S_JAL;
                    default:      state_next = S_FETCH;
                endcase
            end
            S_MEMADR:   state_next = (bus.instrucOp == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_ready) state_next = S_MEMWB;
            S_MEMWRITE: if (mem_ready) state_next = S_FETCH;
            S_EXECUTER, S_EXECUTEI, S_JAL: state_next = S_ALUWB;
            default:    state_next = S_FETCH;
        endcase
    end

    always_comb begin
        pc_update     = 1'b0;
        branch        = 1'b0;
        ir_write_raw  = 1'b0;
        mem_req_raw   = 1'b0;
        mem_write_raw = 1'b0;
        reg_write_raw = 1'b0;
        adr_src_raw   = 1'b0;
        illegal_raw   = 1'b0;
        alu_op        = ALUOP_ADD;
        result_src    = RES_ALUOUT;
        src_a         = SRCA_PC;
        src_b         = SRCB_RS2;
        case (state)
            S_FETCH: begin
                mem_req_raw  = 1'b1;
                ir_write_raw = mem_ready;
                pc_update    = mem_ready;
                src_b        = SRCB_FOUR;
                result_src   = RES_ALURESULT;
            end
            S_DECODE: begin
                src_a       = SRCA_OLDPC;
                src_b       = SRCB_IMM;
                illegal_raw = ~is_supported(bus.instrucOp);
            end
            S_MEMADR: begin
                src_a = SRCA_RS1;
                src_b = SRCB_IMM;
            end
            S_MEMREAD: begin
                mem_req_raw = 1'b1;
                adr_src_raw = 1'b1;
            end
            S_MEMWB: begin
                result_src    = RES_MEMDATA;
                reg_write_raw = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req_raw   = 1'b1;
                adr_src_raw   = 1'b1;
                mem_write_raw = 1'b1;
            end
            S_EXECUTER: begin
                src_a  = SRCA_RS1;
                alu_op = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                src_a  = SRCA_RS1;
                src_b  = SRCB_IMM;
                alu_op = ALUOP_FUNCT;
            end
            S_ALUWB: reg_write_raw = 1'b1;
            S_BEQ: begin
                src_a  = SRCA_RS1;
                alu_op = ALUOP_SUB;
                branch = 1'b1;
            end
            S_JAL: begin
                src_a     = SRCA_OLDPC;
                src_b     = SRCB_FOUR;
                pc_update = 1'b1;
            end
            default: ;
        endcase
    end

    // Strobes are masked by reset itself so nothing fires while it is held.
    assign bus.pcWrite   = ~reset & (pc_update | (branch & bus.zero));
    assign bus.irWrite   = ~reset & ir_write_raw;
    assign bus.memReq    = ~reset & mem_req_raw;
    assign bus.memWrite  = ~reset & mem_write_raw;
    assign bus.regWrite  = ~reset & reg_write_raw;
    assign bus.illegalOp = ~reset & illegal_raw;
    assign bus.adrSrc    = adr_src_raw;
    assign bus.resultSrc = result_src;
    assign bus.aluSrcA   = src_a;
    assign bus.aluSrcB   = src_b;

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (bus.funct3),
        .op_b5       (bus.instrucOp[5]),
        .funct7b5    (bus.funct7b5),
        .alu_control (bus.aluControl)
    );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: a per-cycle vector table walking every
// instruction class, plus hand sequences for reset abort and memory waits.
module tb_multicycle_ctrl;

    logic clk = 1'b0;
    logic reset;

    multicycle_ctrl_if bus();

    multicycle_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       zero;
        logic       ready;
        logic [15:0] exp;
    } vec_t;

    int checks   = 0;
    int failures = 0;
    vec_t vecs[$];

    // {pcWrite, irWrite, adrSrc, memWrite, memReq, regWrite, resultSrc, aluSrcA, aluSrcB, aluControl, illegalOp}
    function automatic logic [15:0] sig(input logic pcw, input logic irw, input logic adr,
                                        input logic mw, input logic mr, input logic rw,
                                        input logic [1:0] res, input logic [1:0] a,
                                        input logic [1:0] b, input logic [2:0] ctl,
                                        input logic ill);
        return {pcw, irw, adr, mw, mr, rw, res, a, b, ctl, ill};
    endfunction

    function automatic vec_t mk(input string n, input logic [6:0] op, input logic [2:0] f3,
                                input logic f7, input logic z, input logic rdy,
                                input logic [15:0] e);
        vec_t v;
        v.name = n; v.op = op; v.f3 = f3; v.f7 = f7; v.zero = z; v.ready = rdy; v.exp = e;
        return v;
    endfunction

    task automatic apply_check(input vec_t v);
        logic [15:0] act;
        bus.instrucOp = v.op;
        bus.funct3    = v.f3;
        bus.funct7b5  = v.f7;
        bus.zero      = v.zero;
        bus.memReady  = v.ready;
        #1;
        act = {bus.pcWrite, bus.irWrite, bus.adrSrc, bus.memWrite, bus.memReq, bus.regWrite,
               bus.resultSrc, bus.aluSrcA, bus.aluSrcB, bus.aluControl, bus.illegalOp};
        checks++;
        if (act !== v.exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", v.name, act, v.exp);
        end
    endtask

    logic [15:0] F_S, FW_S, D_S, DI_S, MA_S, MR_S, MWB_S, MW_S, AWB_S, JAL_S, RST_S;

    function automatic logic [15:0] exr(input logic [2:0] ctl);
        return sig(0,0,0,0,0,0,2'b00,2'b10,2'b00,ctl,0);
    endfunction
    function automatic logic [15:0] exi(input logic [2:0] ctl);
        return sig(0,0,0,0,0,0,2'b00,2'b10,2'b01,ctl,0);
    endfunction
    function automatic logic [15:0] beq(input logic z);
        return sig(z,0,0,0,0,0,2'b00,2'b10,2'b00,3'b001,0);
    endfunction

    initial begin
        F_S   = sig(1,1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,0);
        FW_S  = sig(0,0,0,0,1,0,2'b10,2'b00,2'b10,3'b000,0);
        D_S   = sig(0,0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,0);
        DI_S  = sig(0,0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,1);
        MA_S  = sig(0,0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,0);
        MR_S  = sig(0,0,1,0,1,0,2'b00,2'b00,2'b00,3'b000,0);
        MWB_S = sig(0,0,0,0,0,1,2'b01,2'b00,2'b00,3'b000,0);
        MW_S  = sig(0,0,1,1,1,0,2'b00,2'b00,2'b00,3'b000,0);
        AWB_S = sig(0,0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,0);
        JAL_S = sig(1,0,0,0,0,0,2'b00,2'b01,2'b10,3'b000,0);
        RST_S = sig(0,0,0,0,0,0,2'b10,2'b00,2'b10,3'b000,0);

        // One row per clock cycle, instructions issued back to back.
        vecs.push_back(mk("radd_fetch",  7'd51, 3'b000, 0, 1, 1, F_S));
        vecs.push_back(mk("radd_decode", 7'd51, 3'b000, 0, 1, 1, D_S));
        vecs.push_back(mk("radd_exec",   7'd51, 3'b000, 0, 1, 1, exr(3'b000)));
        vecs.push_back(mk("radd_wb",     7'd51, 3'b000, 0, 1, 1, AWB_S));
        vecs.push_back(mk("rsub_fetch",  7'd51, 3'b000, 1, 1, 1, F_S));
        vecs.push_back(mk("rsub_decode", 7'd51, 3'b000, 1, 1, 1, D_S));
        vecs.push_back(mk("rsub_exec",   7'd51, 3'b000, 1, 1, 1, exr(3'b001)));
        vecs.push_back(mk("rsub_wb",     7'd51, 3'b000, 1, 1, 1, AWB_S));
        vecs.push_back(mk("rslt_fetch",  7'd51, 3'b010, 0, 1, 1, F_S));
        vecs.push_back(mk("rslt_decode", 7'd51, 3'b010, 0, 1, 1, D_S));
        vecs.push_back(mk("rslt_exec",   7'd51, 3'b010, 0, 1, 1, exr(3'b101)));
        vecs.push_back(mk("rslt_wb",     7'd51, 3'b010, 0, 1, 1, AWB_S));
        vecs.push_back(mk("rand_fetch",  7'd51, 3'b111, 0, 1, 1, F_S));
        vecs.push_back(mk("rand_decode", 7'd51, 3'b111, 0, 1, 1, D_S));
        vecs.push_back(mk("rand_exec",   7'd51, 3'b111, 0, 1, 1, exr(3'b010)));
        vecs.push_back(mk("rand_wb",     7'd51, 3'b111, 0, 1, 1, AWB_S));
        vecs.push_back(mk("rdef_fetch",  7'd51, 3'b100, 1, 1, 1, F_S));
        vecs.push_back(mk("rdef_decode", 7'd51, 3'b100, 1, 1, 1, D_S));
        vecs.push_back(mk("rdef_exec",   7'd51, 3'b100, 1, 1, 1, exr(3'b000)));
        vecs.push_back(mk("rdef_wb",     7'd51, 3'b100, 1, 1, 1, AWB_S));
        vecs.push_back(mk("ior_fetch",   7'd19, 3'b110, 0, 1, 1, F_S));
        vecs.push_back(mk("ior_decode",  7'd19, 3'b110, 0, 1, 1, D_S));
        vecs.push_back(mk("ior_exec",    7'd19, 3'b110, 0, 1, 1, exi(3'b011)));
        vecs.push_back(mk("ior_wb",      7'd19, 3'b110, 0, 1, 1, AWB_S));
        vecs.push_back(mk("iadd_fetch",  7'd19, 3'b000, 1, 1, 1, F_S));
        vecs.push_back(mk("iadd_decode", 7'd19, 3'b000, 1, 1, 1, D_S));
        vecs.push_back(mk("iadd_exec",   7'd19, 3'b000, 1, 1, 1, exi(3'b000)));
        vecs.push_back(mk("iadd_wb",     7'd19, 3'b000, 1, 1, 1, AWB_S));
        vecs.push_back(mk("lw_fetch",    7'd3,  3'b010, 0, 1, 1, F_S));
        vecs.push_back(mk("lw_decode",   7'd3,  3'b010, 0, 1, 1, D_S));
        vecs.push_back(mk("lw_memadr",   7'd3,  3'b010, 0, 1, 1, MA_S));
        vecs.push_back(mk("lw_memread",  7'd3,  3'b010, 0, 1, 1, MR_S));
        vecs.push_back(mk("lw_memwb",    7'd3,  3'b010, 0, 1, 1, MWB_S));
        vecs.push_back(mk("sw_fetch",    7'd35, 3'b010, 0, 1, 1, F_S));
        vecs.push_back(mk("sw_decode",   7'd35, 3'b010, 0, 1, 1, D_S));
        vecs.push_back(mk("sw_memadr",   7'd35, 3'b010, 0, 1, 1, MA_S));
        vecs.push_back(mk("sw_memwrite", 7'd35, 3'b010, 0, 1, 1, MW_S));
        vecs.push_back(mk("beq1_fetch",  7'd99, 3'b000, 0, 1, 1, F_S));
        vecs.push_back(mk("beq1_decode", 7'd99, 3'b000, 0, 1, 1, D_S));
        vecs.push_back(mk("beq1_taken",  7'd99, 3'b000, 0, 1, 1, beq(1'b1)));
        vecs.push_back(mk("beq0_fetch",  7'd99, 3'b000, 0, 0, 1, F_S));
        vecs.push_back(mk("beq0_decode", 7'd99, 3'b000, 0, 0, 1, D_S));
        vecs.push_back(mk("beq0_nottkn", 7'd99, 3'b000, 0, 0, 1, beq(1'b0)));
        vecs.push_back(mk("jal_fetch",   7'd111, 3'b000, 0, 1, 1, F_S));
        vecs.push_back(mk("jal_decode",  7'd111, 3'b000, 0, 1, 1, D_S));
        vecs.push_back(mk("jal_jal",     7'd111, 3'b000, 0, 1, 1, JAL_S));
        vecs.push_back(mk("jal_wb",      7'd111, 3'b000, 0, 1, 1, AWB_S));
        vecs.push_back(mk("ill_fetch",   7'h7F, 3'b000, 0, 1, 1, F_S));
        vecs.push_back(mk("ill_decode",  7'h7F, 3'b000, 0, 1, 1, DI_S));
        vecs.push_back(mk("ill_next",    7'd35, 3'b010, 0, 1, 1, F_S));

        bus.instrucOp = 7'd0;
        bus.funct3    = 3'd0;
        bus.funct7b5  = 1'b0;
        bus.zero      = 1'b1;
        bus.memReady  = 1'b1;
        reset         = 1'b1;

        @(negedge clk);
        apply_check(mk("reset_hold", 7'd51, 3'b000, 0, 1, 1, RST_S));
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) begin
            apply_check(vecs[i]);
            @(negedge clk);
        end

        // Reset mid-store: the write strobe must vanish without waiting for a clock.
        apply_check(mk("rst_sw_decode",   7'd35, 3'b010, 0, 1, 1, D_S));
        @(negedge clk);
        apply_check(mk("rst_sw_memadr",   7'd35, 3'b010, 0, 1, 1, MA_S));
        @(negedge clk);
        apply_check(mk("rst_sw_memwrite", 7'd35, 3'b010, 0, 1, 1, MW_S));
        reset = 1'b1;
        apply_check(mk("rst_async_drop",  7'd35, 3'b010, 0, 1, 1, RST_S));
        @(posedge clk);
        @(negedge clk);
        apply_check(mk("rst_still_held",  7'd51, 3'b000, 0, 1, 1, RST_S));
        reset = 1'b0;
        apply_check(mk("rst_rel_fetch",   7'd51, 3'b000, 0, 1, 1, F_S));
        @(negedge clk);
        apply_check(mk("rst_rel_decode",  7'd51, 3'b000, 0, 1, 1, D_S));
        @(negedge clk);
        apply_check(mk("rst_rel_exec",    7'd51, 3'b000, 0, 1, 1, exr(3'b000)));
        @(negedge clk);
        apply_check(mk("rst_rel_wb",      7'd51, 3'b000, 0, 1, 1, AWB_S));
        @(negedge clk);

`ifdef MEM_WAIT_EN
        apply_check(mk("wait_fetch0",  7'd35, 3'b010, 0, 1, 0, FW_S));
        @(negedge clk);
        apply_check(mk("wait_fetch1",  7'd35, 3'b010, 0, 1, 0, FW_S));
        @(negedge clk);
        apply_check(mk("wait_fetchok", 7'd35, 3'b010, 0, 1, 1, F_S));
        @(negedge clk);
        apply_check(mk("wait_decode",  7'd35, 3'b010, 0, 1, 1, D_S));
        @(negedge clk);
        apply_check(mk("wait_memadr",  7'd35, 3'b010, 0, 1, 1, MA_S));
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            apply_check(mk("wait_mw_hold", 7'd35, 3'b010, 0, 1, 0, MW_S));
            @(negedge clk);
        end
        apply_check(mk("wait_mw_done", 7'd35, 3'b010, 0, 1, 1, MW_S));
        @(negedge clk);
        apply_check(mk("wait_after",   7'd35, 3'b010, 0, 1, 1, F_S));
`else
        apply_check(mk("nowait_fetch",  7'd35, 3'b010, 0, 1, 0, F_S));
        @(negedge clk);
        apply_check(mk("nowait_decode", 7'd35, 3'b010, 0, 1, 0, D_S));
        @(negedge clk);
        apply_check(mk("nowait_memadr", 7'd35, 3'b010, 0, 1, 0, MA_S));
        @(negedge clk);
        apply_check(mk("nowait_mw",     7'd35, 3'b010, 0, 1, 0, MW_S));
        @(negedge clk);
        apply_check(mk("nowait_after",  7'd35, 3'b010, 0, 1, 1, F_S));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

- Main control FSM for the multi-cycle RV32I core.
- Each cycle it sequences one step of the shared datapath: PC, instruction register, unified memory, register file and ALU.
- It decodes the opcode latched in the instruction register and drives every datapath mux select and write enable.
- It sits beside the datapath and owns the only next-state register for instruction sequencing.

## Interface
Parameters:
- None. Opcodes, state encodings and mux encodings come from the shared package.

Ports:
- clk  in  1  single core clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high.
- instrucOp  in  7  opcode field instruc[6:0] from the instruction register.
- funct3  in  3  instruc[14:12].
- funct7b5  in  1  instruc[30].
- zero  in  1  ALU zero flag.
- memReady  in  1  memory has completed the current access (used only under MEM_WAIT_EN).
- pcWrite  out  1  PC register enable.
- irWrite  out  1  instruction-register / oldPC enable.
- adrSrc  out  1  memory address select: 0 = PC, 1 = ALU result register.
- memWrite  out  1  memory write strobe.
- memReq  out  1  memory access request.
- regWrite  out  1  register-file write enable.
- resultSrc  out  2  result select: 00 = ALUOut, 01 = memory data, 10 = ALU result.
- aluSrcA  out  2  ALU A select: 00 = PC, 01 = oldPC, 10 = rs1.
- aluSrcB  out  2  ALU B select: 00 = rs2, 01 = immediate, 10 = constant 4.
- aluControl  out  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- illegalOp  out  1  one-cycle pulse in DECODE when the opcode is unsupported.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL.
- Supported opcodes: lw = 3, I-ALU = 19, sw = 35, R-type = 51, beq = 99, jal = 111.
- Transitions:
  - FETCH → DECODE.
  - DECODE: lw/sw → MEMADR; 51 → EXECUTER; 19 → EXECUTEI; 99 → BEQ; 111 → JAL; any other opcode → FETCH with illegalOp = 1.
  - MEMADR: lw → MEMREAD; sw → MEMWRITE.
  - MEMREAD → MEMWB.
  - EXECUTER, EXECUTEI, JAL → ALUWB.
  - MEMWB, MEMWRITE, ALUWB, BEQ → FETCH.
- Outputs per state (signals not listed are 0 or 00):
  - FETCH: memReq = 1, irWrite = 1, aluSrcA = 00, aluSrcB = 10, aluOp = 00, resultSrc = 10, pcUpdate = 1.
  - DECODE: aluSrcA = 01, aluSrcB = 01, aluOp = 00.
  - MEMADR: aluSrcA = 10, aluSrcB = 01, aluOp = 00.
  - MEMREAD: memReq = 1, adrSrc = 1.
  - MEMWB: resultSrc = 01, regWrite = 1.
  - MEMWRITE: memReq = 1, adrSrc = 1, memWrite = 1.
  - EXECUTER: aluSrcA = 10, aluSrcB = 00, aluOp = 10.
  - EXECUTEI: aluSrcA = 10, aluSrcB = 01, aluOp = 10.
  - ALUWB: resultSrc = 00, regWrite = 1.
  - BEQ: aluSrcA = 10, aluSrcB = 00, aluOp = 01, branch = 1.
  - JAL: aluSrcA = 01, aluSrcB = 10, aluOp = 00, pcUpdate = 1.
- pcWrite = pcUpdate | (branch & zero).
- ALU decode (internal aluOp, 2 bits):
  - 00 → add; 01 → sub.
  - 10 decodes funct3: 000 → sub if instrucOp[5] & funct7b5, else add; 010 → slt; 110 → or; 111 → and; other funct3 → add.
- Reset:
  - State goes asynchronously to FETCH.
  - While reset is high, pcWrite, irWrite, memWrite, memReq, regWrite and illegalOp are forced to 0; selects hold FETCH values.
  - Reset asserted mid-instruction abandons the instruction; no partial write is issued after reset is asserted.

## Timing
- Moore outputs, decoded combinationally from the state register.
- Exception: pcWrite in BEQ also depends on zero in the same cycle.
- Cycles per instruction (no wait states): lw 5, sw 4, R-type 4, I-ALU 4, jal 4, beq 3, illegal 2.
- First FETCH strobes occur in the first cycle after reset deasserts.

## Configuration
- MEM_WAIT_EN defined:
  - FETCH, MEMREAD and MEMWRITE hold their state until memReady = 1.
  - In FETCH, irWrite and pcWrite assert only in the memReady cycle.
  - memWrite and memReq stay high for every cycle of the hold.
- MEM_WAIT_EN undefined: memReady is ignored (treated as 1); the port remains present.

## Structure
- Package riscv_ctrl_pkg holds:
  - state enum;
  - opcode localparams;
  - resultSrc / aluSrcA / aluSrcB / aluControl encodings;
  - aluOp encoding.
- Sub-module alu_decoder: combinational aluOp, funct3, instrucOp[5], funct7b5 → aluControl.

## Test plan
- Reset, then R-type add (op 51, funct3 000, funct7b5 0) → FETCH, DECODE, EXECUTER, ALUWB; regWrite = 1 only in ALUWB; aluControl = 000 in EXECUTER.
- lw (op 3) → 5-state path; MEMWB asserts resultSrc = 01 and regWrite = 1; MEMREAD has adrSrc = 1 and memWrite = 0.
- beq (op 99) with zero = 1 → pcWrite = 1 in BEQ; with zero = 0 → pcWrite = 0; both cases return to FETCH.
- Opcode 0x7F → illegalOp pulses exactly one cycle in DECODE; next state is FETCH; no write strobes asserted.
- sw (op 35) with MEM_WAIT_EN and memReady low for 3 cycles in MEMWRITE → memWrite held high for 4 cycles, then FETCH.
- Reset asserted during MEMWRITE → memWrite drops to 0 immediately (asynchronously); state is FETCH after reset release.
